// File: rtl/resp_fifo_pkg.sv
// resp_fifo_pkg: shared constants for the slave-to-master response FIFO port.
//   - default PicoBlaze port addresses
//   - bit positions inside the status byte
//   - interrupt request FSM encoding
package resp_fifo_pkg;

  localparam logic [7:0] DEF_WR_PORT      = 8'h10;
  localparam logic [7:0] DEF_RD_DATA_PORT = 8'h20;
  localparam logic [7:0] DEF_RD_STAT_PORT = 8'h21;
  localparam logic [7:0] DEF_RD_CNT_PORT  = 8'h22;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_THR   = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_UNF   = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE       = 2'd0,
    IRQ_REQ        = 2'd1,
    IRQ_ARMED_WAIT = 2'd2
  } irq_state_e;

endpackage

// File: rtl/resp_fifo_core.sv
// resp_fifo_core: storage, pointers, occupancy and sticky error flags.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   push_req_i/pop_req_i  decoded push / pop requests
//   wr_data_i           byte to push
//   clr_sticky_i        clear overflow/underflow (status read)
//   head_o              entry at the read pointer
//   count_o/count_next_o  current and next-state occupancy
//   full_o/empty_o      registered flags coherent with count_o
//   overflow_o/underflow_o  sticky error flags
module resp_fifo_core #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_req_i,
  input  logic              pop_req_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_sticky_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  count_next_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop;

  always_comb begin
    pop      = pop_req_i && !empty_q;
    // a pop in the same cycle frees the slot a full FIFO needs
    push     = push_req_i && (!full_q || pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    // a new error event in the clearing cycle keeps the flag set
    ovf_d = ovf_q;
    if (push_req_i && !push) ovf_d = 1'b1;
    else if (clr_sticky_i)   ovf_d = 1'b0;
    unf_d = unf_q;
    if (pop_req_i && empty_q) unf_d = 1'b1;
    else if (clr_sticky_i)    unf_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

endmodule

// File: rtl/resp_fifo_port.sv
// resp_fifo_port: return-path FIFO endpoint, slave PicoBlaze -> master PicoBlaze.
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   wr_port_id/wr_data/wr_strobe slave OUTPUT bus
//   rd_port_id/rd_strobe         master INPUT bus
//   rd_data                      registered byte for master in_port
//   interrupt/interrupt_ack      level-threshold request with KCPSM6 ack
//   full/empty/overflow/underflow  FIFO status
//
// Interrupt FSM:
//   state          | meaning
//   IRQ_IDLE       | below threshold, waiting for a crossing
//   IRQ_REQ        | interrupt asserted until acked
//   IRQ_ARMED_WAIT | acked, waiting for occupancy to fall below threshold
module resp_fifo_port
  import resp_fifo_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter int         DATA_W       = 8,
  parameter int         THRESHOLD    = 4,
  parameter logic [7:0] WR_PORT      = DEF_WR_PORT,
  parameter logic [7:0] RD_DATA_PORT = DEF_RD_DATA_PORT,
  parameter logic [7:0] RD_STAT_PORT = DEF_RD_STAT_PORT,
  parameter logic [7:0] RD_CNT_PORT  = DEF_RD_CNT_PORT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        wr_port_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_strobe,
  input  logic [7:0]        rd_port_id,
  input  logic              rd_strobe,
  output logic [DATA_W-1:0] rd_data,
  output logic              interrupt,
  input  logic              interrupt_ack,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESHOLD);

  logic              push_req, pop_req, stat_rd;
  logic [DATA_W-1:0] head, status, rd_data_d, rd_data_q;
  logic [CNT_W-1:0]  count, count_next;
  irq_state_e        state_q;
  logic              irq_q;

  resp_fifo_core #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_core (
    .clock        (clock),
    .reset        (reset),
    .push_req_i   (push_req),
    .pop_req_i    (pop_req),
    .wr_data_i    (wr_data),
    .clr_sticky_i (stat_rd),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty),
    .overflow_o   (overflow),
    .underflow_o  (underflow)
  );

  always_comb begin
    push_req = wr_strobe && (wr_port_id == WR_PORT);
    pop_req  = rd_strobe && (rd_port_id == RD_DATA_PORT);
    stat_rd  = rd_strobe && (rd_port_id == RD_STAT_PORT);
    status             = '0;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL]  = full;
    status[STAT_THR]   = (count >= THR);
    status[STAT_OVF]   = overflow;
    status[STAT_UNF]   = underflow;
    // registered every cycle from port_id; strobe only gates side effects
    rd_data_d = '0;
    if (rd_port_id == RD_DATA_PORT)      rd_data_d = empty ? '0 : head;
    else if (rd_port_id == RD_STAT_PORT) rd_data_d = status;
    else if (rd_port_id == RD_CNT_PORT)  rd_data_d = DATA_W'(count);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (count_next >= THR) begin
            state_q <= IRQ_REQ;
            irq_q   <= 1'b1;
          end
        end
        // request holds until acked even if occupancy has already dropped
        IRQ_REQ: begin
          if (interrupt_ack) begin
            state_q <= IRQ_ARMED_WAIT;
            irq_q   <= 1'b0;
          end
        end
        IRQ_ARMED_WAIT: begin
          if (count_next < THR) state_q <= IRQ_IDLE;
        end
        default: begin
          state_q <= IRQ_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_resp_fifo_port.sv
module tb_resp_fifo_port;
  import resp_fifo_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] wr_port_id, wr_data, rd_port_id, rd_data;
  logic       wr_strobe, rd_strobe, interrupt, interrupt_ack;
  logic       full, empty, overflow, underflow;

  always #5 clock = ~clock;

  resp_fifo_port dut (
    .clock         (clock),
    .reset         (reset),
    .wr_port_id    (wr_port_id),
    .wr_data       (wr_data),
    .wr_strobe     (wr_strobe),
    .rd_port_id    (rd_port_id),
    .rd_strobe     (rd_strobe),
    .rd_data       (rd_data),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  typedef struct {
    logic [7:0] port;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // one bus cycle starting and ending on a falling edge
  task automatic step(input bit do_push, input logic [7:0] b,
                      input bit do_rd, input logic [7:0] port, input logic [7:0] ev);
    wr_strobe  = do_push;
    wr_port_id = do_push ? DEF_WR_PORT : 8'h00;
    wr_data    = b;
    rd_strobe  = do_rd;
    rd_port_id = do_rd ? port : 8'h00;
    if (do_rd) exp_q.push_back('{port: port, val: ev});
    @(negedge clock);
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    rd_port_id = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] ev);
    step(1'b0, 8'h00, 1'b1, port, ev);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    @(negedge clock);
    interrupt_ack = 1'b0;
  endtask

  // monitor: every read strobe produces rd_data one edge later
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (rd_strobe) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected port=%h actual=%h", rd_port_id, rd_data);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rd_data !== e.val) begin
            errors++;
            $display("FAIL rd_port_%h actual=%h required=%h", e.port, rd_data, e.val);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; wr_port_id = 0; wr_data = 0; wr_strobe = 0;
    rd_port_id = 0; rd_strobe = 0; interrupt_ack = 0;
    repeat (2) @(negedge clock);
    chk("rst_empty", {7'b0, empty}, 8'h01);
    chk("rst_full", {7'b0, full}, 8'h00);
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    chk("rst_flags", {6'b0, overflow, underflow}, 8'h00);
    chk("rst_rd_data", rd_data, 8'h00);
    reset = 1'b1;
    @(negedge clock);

    // threshold interrupt
    push(8'h01); push(8'h02); push(8'h03);
    chk("irq_below", {7'b0, interrupt}, 8'h00);
    push(8'h04);
    chk("irq_rise", {7'b0, interrupt}, 8'h01);
    ack();
    chk("irq_acked", {7'b0, interrupt}, 8'h00);
    push(8'h05);
    chk("irq_no_rearm", {7'b0, interrupt}, 8'h00);
    rd(DEF_RD_CNT_PORT, 8'h05);
    rd(DEF_RD_DATA_PORT, 8'h01);
    rd(DEF_RD_DATA_PORT, 8'h02);
    chk("irq_cnt3", {7'b0, interrupt}, 8'h00);
    push(8'h06);
    chk("irq_recross", {7'b0, interrupt}, 8'h01);
    ack();
    push(8'h07);

    // asynchronous reset mid-stream with count 5
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_empty", {7'b0, empty}, 8'h01);
    chk("mid_rst_full", {7'b0, full}, 8'h00);
    chk("mid_rst_irq", {7'b0, interrupt}, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    rd(DEF_RD_CNT_PORT, 8'h00);
    push(8'hA5);
    rd(DEF_RD_DATA_PORT, 8'hA5);
    chk("after_rst_empty", {7'b0, empty}, 8'h01);

    // fill, overflow, drain with pointer wrap
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("fill_full", {7'b0, full}, 8'h01);
    chk("fill_irq", {7'b0, interrupt}, 8'h01);
    push(8'hFF);
    chk("ovf_full", {7'b0, full}, 8'h01);
    chk("ovf_flag", {7'b0, overflow}, 8'h01);
    rd(DEF_RD_CNT_PORT, 8'h10);
    ack();
    for (int i = 0; i < 16; i++) rd(DEF_RD_DATA_PORT, 8'h10 + 8'(i));
    chk("drain_empty", {7'b0, empty}, 8'h01);
    rd(DEF_RD_STAT_PORT, 8'h09);
    chk("ovf_cleared", {7'b0, overflow}, 8'h00);
    rd(DEF_RD_STAT_PORT, 8'h01);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    step(1'b1, 8'h77, 1'b1, DEF_RD_DATA_PORT, 8'h20);
    chk("fullpp_full", {7'b0, full}, 8'h01);
    chk("fullpp_ovf", {7'b0, overflow}, 8'h00);
    rd(DEF_RD_CNT_PORT, 8'h10);
    ack();
    for (int i = 1; i < 16; i++) rd(DEF_RD_DATA_PORT, 8'h20 + 8'(i));
    rd(DEF_RD_DATA_PORT, 8'h77);
    chk("fullpp_empty", {7'b0, empty}, 8'h01);

    // underflow
    rd(DEF_RD_DATA_PORT, 8'h00);
    chk("unf_flag", {7'b0, underflow}, 8'h01);
    chk("unf_empty", {7'b0, empty}, 8'h01);
    rd(DEF_RD_CNT_PORT, 8'h00);
    rd(DEF_RD_STAT_PORT, 8'h11);
    rd(DEF_RD_STAT_PORT, 8'h01);

    // empty with simultaneous push and pop
    step(1'b1, 8'h3C, 1'b1, DEF_RD_DATA_PORT, 8'h00);
    chk("emptypp_unf", {7'b0, underflow}, 8'h01);
    chk("emptypp_empty", {7'b0, empty}, 8'h00);
    rd(DEF_RD_CNT_PORT, 8'h01);
    rd(DEF_RD_DATA_PORT, 8'h3C);
    rd(DEF_RD_STAT_PORT, 8'h11);
    rd(DEF_RD_STAT_PORT, 8'h01);

    // occupancy falls below threshold while request is pending
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    chk("pend_irq", {7'b0, interrupt}, 8'h01);
    rd(DEF_RD_DATA_PORT, 8'hB0);
    rd(DEF_RD_DATA_PORT, 8'hB1);
    chk("pend_hold", {7'b0, interrupt}, 8'h01);
    ack();
    chk("pend_acked", {7'b0, interrupt}, 8'h00);
    push(8'hC0);
    chk("pend_cnt3", {7'b0, interrupt}, 8'h00);
    push(8'hC1);
    chk("pend_recross", {7'b0, interrupt}, 8'h01);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
